// File: rtl/fpm_arbiter.sv
// -----------------------------------------------------------------------------
// fpm_arbiter
//
// Round-robin arbiter and sequencer sharing one floating-point multiplier among
// NREQ requesters. One operation may issue per cycle. The winning requester's
// operands are registered onto fp_X/fp_Y/r_mode. A tag carrying the requester
// id travels down a LAT+1 stage delay line that matches the multiplier latency.
// When the tag reaches the end, the multiplier result and flags are registered
// and returned to that requester with a one-cycle strobe.
//
// Handshake: a request is taken in any cycle where req_valid[i] && req_ready[i].
// req_ready is one-hot (or zero) and may depend on req_valid. Requesters hold
// req_valid and operands until taken. Responses have no backpressure.
//
// Optional feature (macro FPM_ARB_STATS_EN):
//   Adds per-requester saturating 16-bit grant counters.
//   stat_sel selects a counter; stat_sel_cnt shows it one cycle later.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   LAT   multiplier latency in cycles (0 = combinational)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  grant enable (low: no new grants, in-flight ops drain)
//   req_valid/ready     per-requester request / one-hot grant
//   req_X, req_Y        packed operands, requester i at [32i+31:32i]
//   req_rmode           packed rounding modes, requester i at [3i+2:3i]
//   fp_X, fp_Y, r_mode  registered multiplier operands
//   fp_Z, ovrf, udrf    multiplier result and flags
//   rsp_valid           one-hot single-cycle response strobe
//   rsp_Z, rsp_ovrf,
//   rsp_udrf            registered result and flags for the strobed requester
//   busy                high while any tag is in the delay line
//   stat_sel,
//   stat_sel_cnt        (FPM_ARB_STATS_EN only) counter select / value
// -----------------------------------------------------------------------------
module fpm_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
`ifdef FPM_ARB_STATS_EN
    input  logic [$clog2(NREQ)-1:0] stat_sel,
    output logic [15:0]             stat_sel_cnt,
`endif
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*32-1:0]      req_X,
    input  logic [NREQ*32-1:0]      req_Y,
    input  logic [NREQ*3-1:0]       req_rmode,
    output logic [31:0]             fp_X,
    output logic [31:0]             fp_Y,
    output logic [2:0]              r_mode,
    input  logic [31:0]             fp_Z,
    input  logic                    ovrf,
    input  logic                    udrf,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [31:0]             rsp_Z,
    output logic                    rsp_ovrf,
    output logic                    rsp_udrf,
    output logic                    busy
);

    localparam int PW = $clog2(NREQ);

    // Round-robin pointer: id of the most recently granted requester.
    logic [PW-1:0]   r_last;

    // Issue stage registers.
    logic [31:0]     r_fp_x;
    logic [31:0]     r_fp_y;
    logic [2:0]      r_rmode;

    // Tag delay line: stage 0 is loaded on the handshake edge, so stage LAT
    // is valid exactly in the cycle whose closing edge samples fp_Z.
    logic [LAT:0]    r_tag_v;
    logic [PW-1:0]   r_tag_id [LAT+1];

    // Response registers.
    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_rsp_z;
    logic            r_rsp_ovrf;
    logic            r_rsp_udrf;

    // Grant search.
    logic            w_found;
    logic [PW-1:0]   w_gnt_id;
    logic [PW-1:0]   w_cand;
    int              w_idx;
    logic            w_hs;

    // Scan requesters starting just after the last winner, wrapping modulo
    // NREQ; the first active one wins.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_cand   = '0;
        w_idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx  = (int'(r_last) + k) % NREQ;
            w_cand = PW'(w_idx);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_gnt_id = w_cand;
            end
        end
    end

    assign w_hs      = w_found & en & ~rst;
    assign req_ready = w_hs ? (NREQ'(1) << w_gnt_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= PW'(NREQ - 1);
            r_fp_x      <= '0;
            r_fp_y      <= '0;
            r_rmode     <= '0;
            r_tag_v     <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag_id[s] <= '0;
            end
            r_rsp_valid <= '0;
            r_rsp_z     <= '0;
            r_rsp_ovrf  <= 1'b0;
            r_rsp_udrf  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last  <= w_gnt_id;
                r_fp_x  <= req_X[32*w_gnt_id +: 32];
                r_fp_y  <= req_Y[32*w_gnt_id +: 32];
                r_rmode <= req_rmode[3*w_gnt_id +: 3];
            end

            // An idle cycle pushes an invalid tag; the id is don't-care then.
            r_tag_v[0]  <= w_hs;
            r_tag_id[0] <= w_gnt_id;
            for (int s = 1; s <= LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end

            // Result data holds between responses; only the strobe clears.
            if (r_tag_v[LAT]) begin
                r_rsp_valid <= NREQ'(1) << r_tag_id[LAT];
                r_rsp_z     <= fp_Z;
                r_rsp_ovrf  <= ovrf;
                r_rsp_udrf  <= udrf;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign fp_X      = r_fp_x;
    assign fp_Y      = r_fp_y;
    assign r_mode    = r_rmode;
    assign rsp_valid = r_rsp_valid;
    assign rsp_Z     = r_rsp_z;
    assign rsp_ovrf  = r_rsp_ovrf;
    assign rsp_udrf  = r_rsp_udrf;
    assign busy      = |r_tag_v;

`ifdef FPM_ARB_STATS_EN
    logic [15:0] r_cnt [NREQ];
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_cnt[i] <= '0;
            end
            r_stat_cnt <= '0;
        end else begin
            // Counters stick at 0xFFFF instead of wrapping.
            if (w_hs && (r_cnt[w_gnt_id] != 16'hFFFF)) begin
                r_cnt[w_gnt_id] <= r_cnt[w_gnt_id] + 16'd1;
            end
            // Selects beyond NREQ-1 (non power-of-two NREQ) read as zero.
            r_stat_cnt <= (int'(stat_sel) < NREQ) ? r_cnt[stat_sel] : 16'd0;
        end
    end

    assign stat_sel_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_fpm_arbiter.sv
module tb_fpm_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                en;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_X;
    logic [NREQ*32-1:0]  req_Y;
    logic [NREQ*3-1:0]   req_rmode;
    logic [31:0]         fp_X, fp_Y, fp_Z;
    logic [2:0]          r_mode;
    logic                ovrf, udrf;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_Z;
    logic                rsp_ovrf, rsp_udrf;
    logic                busy;
`ifdef FPM_ARB_STATS_EN
    logic [1:0]          stat_sel;
    logic [15:0]         stat_sel_cnt;
`endif

    fpm_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef FPM_ARB_STATS_EN
        .stat_sel     (stat_sel),
        .stat_sel_cnt (stat_sel_cnt),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_X     (req_X),
        .req_Y     (req_Y),
        .req_rmode (req_rmode),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .rsp_valid (rsp_valid),
        .rsp_Z     (rsp_Z),
        .rsp_ovrf  (rsp_ovrf),
        .rsp_udrf  (rsp_udrf),
        .busy      (busy)
    );

    // ---------------- multiplier model (normal numbers, truncating) --------
    function automatic logic [33:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] ma, mb, p;
        int          e;
        logic [22:0] m;
        logic [31:0] z;
        logic        ov, ud;
        s  = a[31] ^ b[31];
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        ov = 1'b0;
        ud = 1'b0;
        if (e >= 255) begin
            z  = {s, 8'hFF, 23'd0};
            ov = 1'b1;
        end else if (e <= 0) begin
            z  = {s, 31'd0};
            ud = 1'b1;
        end else begin
            z = {s, e[7:0], m};
        end
        return {z, ov, ud};
    endfunction

    // Two-cycle pipeline: operands in cycle T+1, result valid in T+1+LAT.
    logic [33:0] m_p1, m_p2;
    always @(posedge clk) begin
        m_p1 <= fmul(fp_X, fp_Y);
        m_p2 <= m_p1;
    end
    assign fp_Z = m_p2[33:2];
    assign ovrf = m_p2[1];
    assign udrf = m_p2[0];

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  id;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   mon_on   = 1'b0;

    // Bench-side view of arbiter state.
    int          tb_last = NREQ - 1;
    logic [31:0] exp_fx = '0;
    logic [31:0] exp_fy = '0;
    logic [2:0]  exp_rm = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response / busy monitor: every cycle, compares against the queue.
    always @(negedge clk) begin : monitor
        logic eb;
        exp_t e;
        if (mon_on) begin
            eb = 1'b0;
            foreach (exp_q[i]) begin
                if (exp_q[i].cyc >= 32'(cyc + 1) && exp_q[i].cyc <= 32'(cyc + LAT + 1)) eb = 1'b1;
            end
            check("busy", 32'(busy), 32'(eb));
            if (exp_q.size() > 0 && exp_q[0].cyc == 32'(cyc)) begin
                e = exp_q.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(NREQ'(1) << e.id));
                check("rsp_Z", rsp_Z, e.z);
                check("rsp_ovrf", 32'(rsp_ovrf), 32'(e.ov));
                check("rsp_udrf", 32'(rsp_udrf), 32'(e.ud));
            end else begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        req_X[32*i +: 32]   = x;
        req_Y[32*i +: 32]   = y;
        req_rmode[3*i +: 3] = rm;
        req_valid[i]        = 1'b1;
    endtask

    // One clock cycle: predict and check the grant, push the expected
    // response, then check the issue registers after the edge.
    task automatic step(input bit auto_clr, output logic [NREQ-1:0] rdy_obs);
        int              g;
        int              idx;
        bit              was_rst;
        logic [NREQ-1:0] pred;
        exp_t            e;
        @(negedge clk);
        g    = -1;
        pred = '0;
        if (en && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (tb_last + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) pred[g] = 1'b1;
        rdy_obs = req_ready;
        check("req_ready", 32'(req_ready), 32'(pred));
        if (g >= 0) begin
            e.cyc = 32'(cyc + LAT + 2);
            e.id  = 3'(g);
            {e.z, e.ov, e.ud} = fmul(req_X[32*g +: 32], req_Y[32*g +: 32]);
            exp_q.push_back(e);
            exp_fx  = req_X[32*g +: 32];
            exp_fy  = req_Y[32*g +: 32];
            exp_rm  = req_rmode[3*g +: 3];
            tb_last = g;
        end
        was_rst = rst;
        @(posedge clk);
        #1;
        if (was_rst) begin
            exp_q.delete();
            exp_fx  = '0;
            exp_fy  = '0;
            exp_rm  = '0;
            tb_last = NREQ - 1;
        end
        if (g >= 0 && auto_clr) req_valid[g] = 1'b0;
        check("fp_X", fp_X, exp_fx);
        check("fp_Y", fp_Y, exp_fy);
        check("r_mode", 32'(r_mode), 32'(exp_rm));
    endtask

    task automatic idle(input int n);
        logic [NREQ-1:0] r;
        for (int i = 0; i < n; i++) step(1'b1, r);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [NREQ-1:0] rdy;
        logic [NREQ-1:0] nm;
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        req_X     = '0;
        req_Y     = '0;
        req_rmode = '0;
`ifdef FPM_ARB_STATS_EN
        stat_sel  = 2'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_fp_X", fp_X, 32'd0);
        check("rst_fp_Y", fp_Y, 32'd0);
        check("rst_r_mode", 32'(r_mode), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_Z", rsp_Z, 32'd0);
        check("rst_rsp_flags", 32'({rsp_ovrf, rsp_udrf}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        mon_on = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 * 2.0 from requester 0.
        set_req(0, 32'h3FC00000, 32'h40000000, 3'd0);
        step(1'b1, rdy);
        check("t1_ready", 32'(rdy), 32'h1);
        idle(6);
        check("t1_rsp_Z", rsp_Z, 32'h40400000);
        check("t1_flags", 32'({rsp_ovrf, rsp_udrf}), 32'd0);

        // Overflow on requester 2, underflow on requester 1.
        set_req(2, 32'h7F000000, 32'h7F000000, 3'd1);
        step(1'b1, rdy);
        idle(5);
        check("ovf_flag", 32'(rsp_ovrf), 32'd1);
        set_req(1, 32'h00800000, 32'h00800000, 3'd2);
        step(1'b1, rdy);
        idle(5);
        check("udf_flag", 32'(rsp_udrf), 32'd1);

        // en low with two ops in flight: they drain, no new grants.
        set_req(0, 32'h40400000, 32'h40000000, 3'd3);
        set_req(3, 32'hC0000000, 32'h3F000000, 3'd4);
        step(1'b1, rdy);
        step(1'b1, rdy);
        en = 1'b0;
        set_req(0, 32'h41000000, 32'h41000000, 3'd5);
        set_req(1, 32'h41100000, 32'h41000000, 3'd5);
        set_req(2, 32'h41200000, 32'h41000000, 3'd5);
        set_req(3, 32'h41300000, 32'h41000000, 3'd5);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, rdy);
            check("en0_ready", 32'(rdy), 32'd0);
        end
        check("en0_busy_low", 32'(busy), 32'd0);
        req_valid = '0;
        en = 1'b1;

        // Three back-to-back ops then reset: no responses may appear.
        set_req(1, 32'h3F800000, 32'h40000000, 3'd0);
        set_req(2, 32'h40000000, 32'h40000000, 3'd0);
        set_req(3, 32'h40400000, 32'h40000000, 3'd0);
        step(1'b1, rdy);
        step(1'b1, rdy);
        step(1'b1, rdy);
        rst = 1'b1;
        step(1'b1, rdy);
        rst = 1'b0;
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_rsp_Z", rsp_Z, 32'd0);
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        idle(6);

        // All four continuously: strict rotation from requester 0.
        set_req(0, 32'h3F800000, 32'h3F800000, 3'd0);
        set_req(1, 32'h40000000, 32'h3FC00000, 3'd1);
        set_req(2, 32'h40400000, 32'h40400000, 3'd2);
        set_req(3, 32'hBF800000, 32'h40800000, 3'd3);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, rdy);
            check("rot_ready", 32'(rdy), 32'(4'b0001 << (k % 4)));
        end
        req_valid = '0;
        idle(6);

        // Random traffic with occasional en drops.
        for (int it = 0; it < 60; it++) begin
            nm = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (nm[i] && !req_valid[i])
                    set_req(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
            end
            en = ($urandom_range(0, 3) != 0);
            step(1'b1, rdy);
        end
        en = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, rdy);
        idle(6);

`ifdef FPM_ARB_STATS_EN
        rst = 1'b1;
        step(1'b1, rdy);
        rst = 1'b0;
        stat_sel = 2'd3;
        set_req(3, 32'h3F800000, 32'h3F800000, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b0, rdy);
        req_valid = '0;
        step(1'b1, rdy);
        check("stat_cnt5", 32'(stat_sel_cnt), 32'd5);
        req_valid[3] = 1'b1;
        for (int i = 0; i < 65535; i++) step(1'b0, rdy);
        req_valid = '0;
        step(1'b1, rdy);
        check("stat_sat", 32'(stat_sel_cnt), 32'hFFFF);
        idle(6);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpm_arbiter.md
# fpm_arbiter

Round-robin arbiter and sequencer that shares one floating-point multiplier (fp_X, fp_Y, r_mode in; fp_Z, ovrf, udrf out) among NREQ requesters. It accepts at most one multiply per cycle and drives the multiplier operands from a registered issue stage. It tags each issued operation through a delay line matching the multiplier latency and routes the result and flags back to the originating requester. It sits between the requester ports and the multiplier DUT in the verification and integration top.

## Interface
- NREQ, 4, number of requesters (2..8)
- LAT, 2, multiplier latency in cycles from fp_X/fp_Y/r_mode stable to fp_Z/ovrf/udrf valid (0 = combinational)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  grant enable; low blocks new grants while in-flight ops drain
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] && req_ready[i]
- req_X, req_Y  in  NREQ*32  operands, requester i at bits [32i+31:32i]
- req_rmode  in  NREQ*3  rounding mode, requester i at [3i+2:3i]
- fp_X, fp_Y  out  32  multiplier operands (registered)
- r_mode  out  3  multiplier rounding mode (registered)
- fp_Z  in  32  multiplier result
- ovrf, udrf  in  1  multiplier overflow / underflow flags
- rsp_valid  out  NREQ  one-hot single-cycle response strobe
- rsp_Z  out  32  result for the strobed requester
- rsp_ovrf, rsp_udrf  out  1  flags for the strobed requester
- busy  out  1  high while any operation is in flight

## Operation
- Round-robin pointer `last`, log2(NREQ) bits, reset to NREQ-1, so requester 0 has first priority after reset.
- Grant: combinational. Search starts at last+1, wraps modulo NREQ. The first i with req_valid[i] gets req_ready[i]=1. When en=0 or rst=1, req_ready=0.
- req_ready may depend on req_valid. Requesters must hold req_valid and operands stable until the handshake completes.
- On a handshake with requester g:
  - fp_X, fp_Y, r_mode load req_X[g], req_Y[g], req_rmode[g] at the next edge.
  - last <= g.
  - A tag {valid=1, id=g} enters the delay line.
- No handshake: fp_X, fp_Y, r_mode hold their values. The tag entering the delay line is invalid.
- Delay line: LAT+1 stages. At its output with valid tag id, the next edge registers:
  - rsp_Z <= fp_Z, rsp_ovrf <= ovrf, rsp_udrf <= udrf
  - rsp_valid <= one-hot(id)
- Invalid tag: rsp_valid <= 0. rsp_Z and flags hold.
- Responses have no backpressure. Requesters must always accept rsp_valid.
- busy = OR of all delay-line valid bits.
- Back-to-back grants are allowed every cycle. Responses return in issue order.

## Timing
- Handshake in cycle T:
  - fp_X/fp_Y/r_mode valid in T+1.
  - fp_Z sampled at end of T+1+LAT.
  - rsp_valid high for exactly one cycle in T+2+LAT. With LAT=2, that is T+4.
- Throughput: one operation per cycle. Up to LAT+2 operations can be in flight.
- Reset values: fp_X=0, fp_Y=0, r_mode=0, rsp_valid=0, rsp_Z=0, rsp_ovrf=0, rsp_udrf=0, busy=0, last=NREQ-1, all tags invalid.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid is produced for operations issued before reset.
- en falling while ops are in flight: no new grants. Existing ops complete normally. busy falls the cycle after the last tag leaves.
- A single requester asserting continuously is granted every cycle. Other requesters are served within NREQ-1 cycles of asserting.

## Configuration
- FPM_ARB_STATS_EN defined adds:
  - Output stat_sel_cnt [15:0] and input stat_sel [log2(NREQ)-1:0].
  - Per-requester 16-bit grant counters that saturate at 0xFFFF and clear on rst.
  - stat_sel_cnt is the registered count for stat_sel, one cycle of latency.
- FPM_ARB_STATS_EN undefined: no counters and no stat ports. Behaviour is otherwise identical.

## Test plan
- Reset, then req 0 only with X=0x3FC00000 (1.5), Y=0x40000000 (2.0), rmode=0, LAT=2 -> handshake in cycle T; fp_X/fp_Y=operands in T+1; rsp_valid=4'b0001 in T+4 with rsp_Z=0x40400000 and both flags 0.
- All four requesters valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; responses return in the same order, each to its own rsp_valid bit.
- Req 2 with X=Y=0x7F000000 (near max) -> rsp_valid[2] with rsp_ovrf=1. Req 1 with X=Y=0x00800000 -> rsp_valid[1] with rsp_udrf=1.
- Issue 3 ops back-to-back, then assert rst for 1 cycle at T+2 -> no rsp_valid for any of them; busy=0 and outputs at reset values the cycle after rst.
- en=0 with all req_valid=1 -> req_ready=0 and fp_X unchanged. With 2 ops in flight, both responses still arrive and busy drops afterwards.
- With FPM_ARB_STATS_EN, grant req 3 five times -> stat_sel=3 reads 5. After 65540 grants the count reads 0xFFFF.
